axi_read_arbiter: RTL and testbench

Shares one AXI read port (AR + R channels) between `REQ_NUM` upstream read masters (ICache refill, DCache refill, page-table walker). Picks one AR request at a time, tags the downstream ID with the requester index, tracks per-requester outstanding bursts, and routes R beats back by ID. Sits between the cache AXI masters and the core's single memory-side AXI port.

---
 rtl/axi_read_arbiter_pkg.sv | 33 +++
 rtl/axi_read_arbiter_rr_arbiter.sv | 64 ++++++
 rtl/axi_read_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_read_arbiter_pkg.sv
// rtl/axi_read_arbiter_pkg.sv - shared AXI encodings and AR payload type for the read arbiter
// Purpose: AXI burst/response encodings, the AR payload struct and the AR FSM state type.
// Ports: none (package).
package axi_read_arbiter_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Payload fields are sized for the widest supported configuration;
  // instances zero-extend into them and slice back out.
  localparam int AXI_MAX_ADDR_WIDTH = 64;
  localparam int AXI_MAX_ID_WIDTH   = 16;

  typedef struct packed {
    logic [AXI_MAX_ADDR_WIDTH-1:0] addr;
    logic [AXI_MAX_ID_WIDTH-1:0]   id;
    logic [7:0]                    len;
    logic [2:0]                    size;
    logic [1:0]                    burst;
  } axi_ar_payload_t;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_t;

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter.sv
// rtl/axi_read_arbiter_rr_arbiter.sv - requester selection for the AXI read arbiter
// Purpose: picks one requester from an eligible mask. With AXI_RARB_RR_EN defined the
//          search is round-robin from an internal pointer that moves to winner+1 on each
//          advance; otherwise the lowest index wins and no pointer is built.
// Ports: clk, rst (async, active-high); req (eligible mask); advance (grant taken);
//        grant (one-hot), grant_idx (binary), grant_valid.
module rr_arbiter #(
  parameter int REQ_NUM   = 2,
  parameter int IDX_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQ_NUM-1:0]   req,
  input  logic                 advance,
  output logic [REQ_NUM-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_valid
);

`ifdef AXI_RARB_RR_EN
  logic [IDX_WIDTH-1:0] ptr;

  always_comb begin
    int j;
    j           = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      j = (int'(ptr) + i) % REQ_NUM;
      if (!grant_valid && req[j]) begin
        grant[j]    = 1'b1;
        grant_idx   = IDX_WIDTH'(j);
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= IDX_WIDTH'((int'(grant_idx) + 1) % REQ_NUM);
    end
  end
`else
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!grant_valid && req[i]) begin
        grant[i]    = 1'b1;
        grant_idx   = IDX_WIDTH'(i);
        grant_valid = 1'b1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{clk, rst, advance};
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - shares one AXI read port between REQ_NUM upstream masters
// Purpose: grants one AR at a time (IDLE/ISSUE FSM), tags m_ar_id with the requester
//          index, limits each requester to MAX_OUTSTANDING bursts, and routes R beats
//          back by the index field of m_r_id. Arbitration mode set by AXI_RARB_RR_EN.
// Ports: clk, rst (async, active-high); s_ar_* per-requester AR; s_r_* routed R;
//        m_ar_* downstream AR; m_r_* downstream R; err_bad_id sticky bad-index flag.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int REQ_NUM         = 2,
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 2,
  localparam int IDX_WIDTH      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [REQ_NUM-1:0]                   s_ar_valid,
  output logic [REQ_NUM-1:0]                   s_ar_ready,
  input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]   s_ar_addr,
  input  logic [REQ_NUM-1:0][ID_WIDTH-1:0]     s_ar_id,
  input  logic [REQ_NUM-1:0][7:0]              s_ar_len,
  input  logic [REQ_NUM-1:0][2:0]              s_ar_size,
  input  logic [REQ_NUM-1:0][1:0]              s_ar_burst,
  output logic [REQ_NUM-1:0]                   s_r_valid,
  input  logic [REQ_NUM-1:0]                   s_r_ready,
  output logic [DATA_WIDTH-1:0]                s_r_data,
  output logic [1:0]                           s_r_resp,
  output logic                                 s_r_last,
  output logic [ID_WIDTH-1:0]                  s_r_id,
  output logic                                 m_ar_valid,
  input  logic                                 m_ar_ready,
  output logic [ADDR_WIDTH-1:0]                m_ar_addr,
  output logic [ID_WIDTH+IDX_WIDTH-1:0]        m_ar_id,
  output logic [7:0]                           m_ar_len,
  output logic [2:0]                           m_ar_size,
  output logic [1:0]                           m_ar_burst,
  input  logic                                 m_r_valid,
  output logic                                 m_r_ready,
  input  logic [DATA_WIDTH-1:0]                m_r_data,
  input  logic [1:0]                           m_r_resp,
  input  logic                                 m_r_last,
  input  logic [ID_WIDTH+IDX_WIDTH-1:0]        m_r_id,
  output logic                                 err_bad_id
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  ar_state_t                        state;
  axi_ar_payload_t                  ar_q;
  axi_ar_payload_t                  sel_pl;
  logic [IDX_WIDTH-1:0]             ar_idx_q;
  logic [REQ_NUM-1:0][CNT_W-1:0]    cnt;
  logic [REQ_NUM-1:0]               eligible;
  logic [REQ_NUM-1:0]               grant;
  logic [IDX_WIDTH-1:0]             grant_idx;
  logic                             grant_valid;
  logic                             take;
  logic [IDX_WIDTH-1:0]             r_idx;
  logic                             r_bad;
  logic                             r_hs;

  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      eligible[i] = s_ar_valid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  rr_arbiter #(
    .REQ_NUM   (REQ_NUM),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (eligible),
    .advance     (take),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // A grant is only offered in IDLE; since the winner was eligible, its
  // valid is already high, so ready doubles as the handshake strobe.
  assign take       = !rst && (state == AR_IDLE) && grant_valid;
  assign s_ar_ready = take ? grant : '0;

  always_comb begin
    sel_pl = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant[i]) begin
        sel_pl.addr  = AXI_MAX_ADDR_WIDTH'(s_ar_addr[i]);
        sel_pl.id    = AXI_MAX_ID_WIDTH'(s_ar_id[i]);
        sel_pl.len   = s_ar_len[i];
        sel_pl.size  = s_ar_size[i];
        sel_pl.burst = s_ar_burst[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= AR_IDLE;
      m_ar_valid <= 1'b0;
      ar_q       <= '0;
      ar_idx_q   <= '0;
    end else begin
      case (state)
        AR_IDLE: begin
          if (grant_valid) begin
            ar_q       <= sel_pl;
            ar_idx_q   <= grant_idx;
            m_ar_valid <= 1'b1;
            state      <= AR_ISSUE;
          end
        end
        AR_ISSUE: begin
          if (m_ar_ready) begin
            m_ar_valid <= 1'b0;
            state      <= AR_IDLE;
          end
        end
        default: state <= AR_IDLE;
      endcase
    end
  end

  assign m_ar_addr  = ar_q.addr[ADDR_WIDTH-1:0];
  assign m_ar_id    = {ar_idx_q, ar_q.id[ID_WIDTH-1:0]};
  assign m_ar_len   = ar_q.len;
  assign m_ar_size  = ar_q.size;
  assign m_ar_burst = ar_q.burst;

  logic unused_ar_bits;
  assign unused_ar_bits = ^ar_q;

  // R path: pure routing on the index field of the downstream ID.
  assign r_idx = m_r_id[ID_WIDTH +: IDX_WIDTH];
  assign r_bad = int'(r_idx) >= REQ_NUM;

  always_comb begin
    m_r_ready = r_bad;  // beats with an unknown index are drained and dropped
    for (int i = 0; i < REQ_NUM; i++) begin
      s_r_valid[i] = m_r_valid && (r_idx == IDX_WIDTH'(i));
      if (r_idx == IDX_WIDTH'(i)) begin
        m_r_ready = s_r_ready[i];
      end
    end
  end

  assign r_hs     = m_r_valid && m_r_ready;
  assign s_r_data = m_r_data;
  assign s_r_resp = m_r_resp;
  assign s_r_last = m_r_last;
  assign s_r_id   = m_r_id[ID_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        logic inc;
        logic dec;
        inc = s_ar_ready[i];
        dec = r_hs && m_r_last && !r_bad && (r_idx == IDX_WIDTH'(i));
        if (inc && !dec) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (dec && !inc && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_bad_id <= 1'b0;
    end else if (m_r_valid && r_bad) begin
      err_bad_id <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - self-checking bench for axi_read_arbiter
module tb_axi_read_arbiter;
  import axi_read_arbiter_pkg::*;

  localparam int RN  = 3;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IXW = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [RN-1:0]           s_ar_valid;
  logic [RN-1:0]           s_ar_ready;
  logic [RN-1:0][AW-1:0]   s_ar_addr;
  logic [RN-1:0][IDW-1:0]  s_ar_id;
  logic [RN-1:0][7:0]      s_ar_len;
  logic [RN-1:0][2:0]      s_ar_size;
  logic [RN-1:0][1:0]      s_ar_burst;
  logic [RN-1:0]           s_r_valid;
  logic [RN-1:0]           s_r_ready;
  logic [DW-1:0]           s_r_data;
  logic [1:0]              s_r_resp;
  logic                    s_r_last;
  logic [IDW-1:0]          s_r_id;
  logic                    m_ar_valid;
  logic                    m_ar_ready;
  logic [AW-1:0]           m_ar_addr;
  logic [IDW+IXW-1:0]      m_ar_id;
  logic [7:0]              m_ar_len;
  logic [2:0]              m_ar_size;
  logic [1:0]              m_ar_burst;
  logic                    m_r_valid;
  logic                    m_r_ready;
  logic [DW-1:0]           m_r_data;
  logic [1:0]              m_r_resp;
  logic                    m_r_last;
  logic [IDW+IXW-1:0]      m_r_id;
  logic                    err_bad_id;

  int n_checks = 0;
  int n_fail   = 0;

  axi_read_arbiter #(
    .REQ_NUM(RN), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_id(s_ar_id), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
    .s_r_last(s_r_last), .s_r_id(s_r_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .m_r_last(m_r_last), .m_r_id(m_r_id), .err_bad_id(err_bad_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic r_beat(input logic [5:0] id);
    m_r_valid = 1'b1;
    m_r_id    = id;
    m_r_last  = 1'b1;
    s_r_ready = '1;
    tick();
    m_r_valid = 1'b0;
    m_r_last  = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [5:0] id;
    logic [2:0] rdy;
    logic [2:0] exp_sv;
    logic       exp_mr;
    logic [3:0] exp_sid;
  } r_vec_t;

  r_vec_t tbl[6];
  logic [2:0] gnt_val[4];
  int         gnt_cyc[4];
  int         ng;
  logic [2:0] exp_g[4];

  initial begin
    tbl[0] = '{1'b1, 6'h03, 3'b111, 3'b001, 1'b1, 4'h3};
    tbl[1] = '{1'b1, 6'h1A, 3'b001, 3'b010, 1'b0, 4'hA};
    tbl[2] = '{1'b1, 6'h2F, 3'b100, 3'b100, 1'b1, 4'hF};
    tbl[3] = '{1'b0, 6'h25, 3'b100, 3'b000, 1'b1, 4'h5};
    tbl[4] = '{1'b1, 6'h00, 3'b110, 3'b001, 1'b0, 4'h0};
    tbl[5] = '{1'b1, 6'h11, 3'b010, 3'b010, 1'b1, 4'h1};
`ifdef AXI_RARB_RR_EN
    exp_g = '{3'b001, 3'b010, 3'b001, 3'b010};
`else
    exp_g = '{3'b001, 3'b001, 3'b010, 3'b010};
`endif

    rst = 1'b1;
    s_ar_valid = '0; s_ar_addr = '0; s_ar_id = '0; s_ar_len = '0;
    s_ar_size = '0; s_ar_burst = '0; s_r_ready = '0; m_ar_ready = 1'b0;
    m_r_valid = 1'b0; m_r_data = '0; m_r_resp = '0; m_r_last = 1'b0; m_r_id = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_m_ar_valid", m_ar_valid, 0);
    check("rst_s_ar_ready", s_ar_ready, 0);
    check("rst_err", err_bad_id, 0);
    check("rst_cnt0", dut.cnt[0], 0);
    check("rst_m_ar_id", m_ar_id, 0);

    // R routing table (no last, so counters untouched)
    for (int i = 0; i < 6; i++) begin
      tick();
      m_r_valid = tbl[i].v;
      m_r_id    = tbl[i].id;
      s_r_ready = tbl[i].rdy;
      m_r_data  = 64'hC0DE_0000_0000_0000 | 64'(i);
      @(negedge clk);
      check($sformatf("tbl%0d_s_r_valid", i), s_r_valid, tbl[i].exp_sv);
      check($sformatf("tbl%0d_m_r_ready", i), m_r_ready, tbl[i].exp_mr);
      check($sformatf("tbl%0d_s_r_id", i), s_r_id, tbl[i].exp_sid);
      check($sformatf("tbl%0d_s_r_data", i), s_r_data, 64'hC0DE_0000_0000_0000 | 64'(i));
    end
    tick();
    m_r_valid = 1'b0; s_r_ready = '0;
    check("tbl_cnt0", dut.cnt[0], 0);

    // Single request
    s_ar_valid = 3'b001; s_ar_addr[0] = 32'h8000_0040; s_ar_id[0] = 4'h3;
    s_ar_len[0] = 8'd7; s_ar_size[0] = 3'd3; s_ar_burst[0] = AXI_BURST_INCR; m_ar_ready = 1'b1;
    @(negedge clk);
    check("single_s_ar_ready", s_ar_ready, 3'b001);
    check("single_m_ar_valid_pre", m_ar_valid, 0);
    tick();
    s_ar_valid = '0;
    @(negedge clk);
    check("single_m_ar_valid", m_ar_valid, 1);
    check("single_m_ar_id", m_ar_id, 6'h03);
    check("single_m_ar_addr", m_ar_addr, 32'h8000_0040);
    check("single_m_ar_len", m_ar_len, 7);
    check("single_m_ar_burst", m_ar_burst, AXI_BURST_INCR);
    tick();
    check("single_m_ar_valid_done", m_ar_valid, 0);
    check("single_cnt_1", dut.cnt[0], 1);
    for (int b = 0; b < 8; b++) begin
      m_r_valid = 1'b1; m_r_id = 6'h03; m_r_last = (b == 7); s_r_ready = 3'b001;
      m_r_data = 64'(b) * 64'h0101;
      @(negedge clk);
      check($sformatf("single_beat%0d_valid", b), s_r_valid, 3'b001);
      check($sformatf("single_beat%0d_data", b), s_r_data, 64'(b) * 64'h0101);
      tick();
      if (b == 6) check("single_cnt_mid", dut.cnt[0], 1);
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
    check("single_cnt_0", dut.cnt[0], 0);

    // Contention between req0 and req1
    s_ar_valid = 3'b011; s_ar_addr[1] = 32'h0000_1000; s_ar_id[1] = 4'h3; m_ar_ready = 1'b1;
    ng = 0;
    for (int cyc = 0; cyc < 20 && ng < 4; cyc++) begin
      @(negedge clk);
      if (s_ar_ready != '0) begin
        gnt_val[ng] = s_ar_ready;
        gnt_cyc[ng] = cyc;
        ng++;
      end
      tick();
    end
    check("cont_grant_count", ng, 4);
    for (int g = 0; g < 4 && g < ng; g++) begin
      check($sformatf("cont_grant%0d", g), gnt_val[g], exp_g[g]);
    end
    if (ng == 4) check("cont_rate", gnt_cyc[3] - gnt_cyc[0], 6);
    tick();
    @(negedge clk);
    check("cont_full_block", s_ar_ready, 0);
    check("cont_cnt0", dut.cnt[0], 2);
    check("cont_cnt1", dut.cnt[1], 2);
    tick();
    s_ar_valid = '0;
    r_beat(6'h00); r_beat(6'h00); r_beat(6'h13); r_beat(6'h13);
    check("cont_drain0", dut.cnt[0], 0);
    check("cont_drain1", dut.cnt[1], 0);

    // Outstanding limit on req1
    s_ar_valid = 3'b010;
    @(negedge clk);
    check("lim_grant_a", s_ar_ready, 3'b010);
    tick(); tick();
    @(negedge clk);
    check("lim_grant_b", s_ar_ready, 3'b010);
    tick(); tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("lim_block%0d", c), s_ar_ready[1], 0);
      tick();
    end
    m_r_valid = 1'b1; m_r_id = 6'h13; m_r_last = 1'b1; s_r_ready = '1;
    @(negedge clk);
    check("lim_block_rbeat", s_ar_ready[1], 0);
    check("lim_r_valid", s_r_valid, 3'b010);
    tick();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    @(negedge clk);
    check("lim_release", s_ar_ready, 3'b010);
    tick();
    s_ar_valid = '0;
    tick();
    check("lim_cnt", dut.cnt[1], 2);
    r_beat(6'h13); r_beat(6'h13);
    check("lim_drain", dut.cnt[1], 0);

    // Downstream backpressure
    m_ar_ready = 1'b0; s_ar_valid = 3'b001; s_ar_addr[0] = 32'hA5A5_0100; s_ar_len[0] = 8'd3;
    tick();
    s_ar_valid = 3'b010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid%0d", c), m_ar_valid, 1);
      check($sformatf("bp_addr%0d", c), m_ar_addr, 32'hA5A5_0100);
      check($sformatf("bp_ready%0d", c), s_ar_ready, 0);
      tick();
    end
    m_ar_ready = 1'b1;
    @(negedge clk);
    check("bp_cycle6_valid", m_ar_valid, 1);
    check("bp_cycle6_len", m_ar_len, 3);
    tick();
    @(negedge clk);
    check("bp_done_valid", m_ar_valid, 0);
    check("bp_next_grant", s_ar_ready, 3'b010);
    tick();
    s_ar_valid = '0;
    tick();
    r_beat(6'h00); r_beat(6'h13);
    check("bp_drain0", dut.cnt[0], 0);
    check("bp_drain1", dut.cnt[1], 0);

    // Simultaneous AR handshake and last beat on req0
    s_ar_valid = 3'b001;
    tick();
    s_ar_valid = '0;
    tick();
    check("sim_cnt_pre", dut.cnt[0], 1);
    s_ar_valid = 3'b001; m_r_valid = 1'b1; m_r_id = 6'h00; m_r_last = 1'b1; s_r_ready = '1;
    @(negedge clk);
    check("sim_ar_ready", s_ar_ready, 3'b001);
    check("sim_m_r_ready", m_r_ready, 1);
    tick();
    s_ar_valid = '0; m_r_valid = 1'b0; m_r_last = 1'b0;
    check("sim_cnt_hold", dut.cnt[0], 1);
    tick();
    r_beat(6'h00);
    check("sim_drain", dut.cnt[0], 0);

    // Bad index, then reset while in ISSUE
    m_r_valid = 1'b1; m_r_id = 6'h35; s_r_ready = '0;
    @(negedge clk);
    check("bad_m_r_ready", m_r_ready, 1);
    check("bad_s_r_valid", s_r_valid, 0);
    tick();
    m_r_valid = 1'b0;
    check("bad_err_set", err_bad_id, 1);
    tick();
    check("bad_err_sticky", err_bad_id, 1);
    m_ar_ready = 1'b0; s_ar_valid = 3'b001;
    tick();
    s_ar_valid = '0;
    @(negedge clk);
    check("rst_pre_valid", m_ar_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", m_ar_valid, 0);
    check("rst_mid_ready", s_ar_ready, 0);
    check("rst_mid_err", err_bad_id, 0);
    check("rst_mid_cnt0", dut.cnt[0], 0);
    check("rst_mid_addr", m_ar_addr, 0);
    check("rst_mid_id", m_ar_id, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_valid", m_ar_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
